// File: rtl/keypad_lock_fsm.sv
// Digital-lock policy: 4-digit code entry, compare, timed unlock, failure counting,
// timed lockout and code reprogramming. Every output is registered.
module keypad_lock_fsm #(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned UNLOCK_CYCLES  = 250_000_000,
    parameter int unsigned FAIL_CYCLES    = 50_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  keypad_value,
    input  logic        keypress,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic        unlocked,
    output logic        program_mode,
    output logic        fail_flag,
    output logic        locked_out,
    output logic [3:0]  fail_count,
    output logic        code_changed,
    output logic [2:0]  rgb
);
    localparam int unsigned TMAX_A = (UNLOCK_CYCLES > FAIL_CYCLES) ? UNLOCK_CYCLES : FAIL_CYCLES;
    localparam int unsigned TMAX   = (TMAX_A > LOCKOUT_CYCLES) ? TMAX_A : LOCKOUT_CYCLES;
    localparam int unsigned TW     = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] UNLOCK_LAST  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] FAIL_LAST    = TW'(FAIL_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    MAX_FAILS_4  = 4'(MAX_FAILS);

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_PROG  = 4'hC;
    localparam logic [3:0] KEY_LOCK  = 4'hD;

    typedef enum logic [2:0] {
        S_ENTRY, S_UNLOCKED, S_PROGRAM, S_FAIL, S_LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   code_q, code_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    fail_q, fail_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          code_changed_q, code_changed_d;
    logic          unlocked_q, unlocked_d;
    logic          program_mode_q, program_mode_d;
    logic          fail_flag_q, fail_flag_d;
    logic          locked_out_q, locked_out_d;
    logic [2:0]    rgb_q, rgb_d;

    logic       is_digit;
    logic [3:0] fail_inc;

    assign is_digit = (keypad_value < 4'hA);
    assign fail_inc = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        buf_d          = buf_q;
        cnt_d          = cnt_q;
        fail_d         = fail_q;
        code_changed_d = 1'b0;

        case (state_q)
            S_ENTRY, S_PROGRAM: begin
                if (keypress) begin
                    if (is_digit) begin
                        if (cnt_q < 3'd4) begin
                            buf_d = {buf_q[11:0], keypad_value};
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (keypad_value == KEY_CLEAR) begin
                        buf_d = 16'h0000;
                        cnt_d = 3'd0;
                    end else if (keypad_value == KEY_ENTER) begin
                        buf_d = 16'h0000;
                        cnt_d = 3'd0;
                        if (state_q == S_ENTRY) begin
                            if (cnt_q == 3'd4 && buf_q == code_q) begin
                                state_d = S_UNLOCKED;
                                fail_d  = 4'd0;
                            end else begin
                                fail_d  = fail_inc;
                                state_d = (fail_inc >= MAX_FAILS_4) ? S_LOCKOUT : S_FAIL;
                            end
                        end else if (cnt_q == 3'd4) begin
                            code_d         = buf_q;
                            code_changed_d = 1'b1;
                            state_d        = S_ENTRY;
                        end else begin
                            state_d = S_UNLOCKED;
                        end
                    end else if (keypad_value == KEY_LOCK && state_q == S_PROGRAM) begin
                        buf_d   = 16'h0000;
                        cnt_d   = 3'd0;
                        state_d = S_ENTRY;
                    end
                end
            end
            S_UNLOCKED: begin
                // Expiry outranks any key landing on the same edge.
                if (timer_q == UNLOCK_LAST) begin
                    state_d = S_ENTRY;
                end else if (keypress && keypad_value == KEY_PROG) begin
                    state_d = S_PROGRAM;
                    buf_d   = 16'h0000;
                    cnt_d   = 3'd0;
                end else if (keypress && keypad_value == KEY_LOCK) begin
                    state_d = S_ENTRY;
                end
            end
            S_FAIL: begin
                if (timer_q == FAIL_LAST) state_d = S_ENTRY;
            end
            S_LOCKOUT: begin
                if (timer_q == LOCKOUT_LAST) begin
                    state_d = S_ENTRY;
                    fail_d  = 4'd0;
                end
            end
            default: state_d = S_ENTRY;
        endcase

        // Untimed states hold the timer at zero so it never wraps.
        if (state_d != state_q || state_q == S_ENTRY || state_q == S_PROGRAM)
            timer_d = '0;
        else
            timer_d = timer_q + TW'(1);

        unlocked_d     = (state_d == S_UNLOCKED) || (state_d == S_PROGRAM);
        program_mode_d = (state_d == S_PROGRAM);
        fail_flag_d    = (state_d == S_FAIL);
        locked_out_d   = (state_d == S_LOCKOUT);
        case (state_d)
            S_UNLOCKED:        rgb_d = 3'b010;
            S_PROGRAM:         rgb_d = 3'b100;
            S_FAIL, S_LOCKOUT: rgb_d = 3'b001;
            default:           rgb_d = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_ENTRY;
            code_q         <= DEFAULT_CODE;
            buf_q          <= 16'h0000;
            cnt_q          <= 3'd0;
            fail_q         <= 4'd0;
            timer_q        <= '0;
            code_changed_q <= 1'b0;
            unlocked_q     <= 1'b0;
            program_mode_q <= 1'b0;
            fail_flag_q    <= 1'b0;
            locked_out_q   <= 1'b0;
            rgb_q          <= 3'b000;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            fail_q         <= fail_d;
            timer_q        <= timer_d;
            code_changed_q <= code_changed_d;
            unlocked_q     <= unlocked_d;
            program_mode_q <= program_mode_d;
            fail_flag_q    <= fail_flag_d;
            locked_out_q   <= locked_out_d;
            rgb_q          <= rgb_d;
        end
    end

    assign entry_digits = buf_q;
    assign digit_count  = cnt_q;
    assign fail_count   = fail_q;
    assign code_changed = code_changed_q;
    assign unlocked     = unlocked_q;
    assign program_mode = program_mode_q;
    assign fail_flag    = fail_flag_q;
    assign locked_out   = locked_out_q;
    assign rgb          = rgb_q;
endmodule

// File: tb/tb_keypad_lock_fsm.sv
// Directed bench for keypad_lock_fsm with shortened timers.
module tb_keypad_lock_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  keypad_value = 4'h0;
    logic        keypress = 1'b0;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        unlocked, program_mode, fail_flag, locked_out, code_changed;
    logic [3:0]  fail_count;
    logic [2:0]  rgb;

    int errors = 0;
    int checks = 0;

    keypad_lock_fsm #(
        .DEFAULT_CODE(16'h1234), .MAX_FAILS(3),
        .UNLOCK_CYCLES(20), .FAIL_CYCLES(10), .LOCKOUT_CYCLES(50)
    ) dut (
        .clk(clk), .rst(rst), .keypad_value(keypad_value), .keypress(keypress),
        .entry_digits(entry_digits), .digit_count(digit_count), .unlocked(unlocked),
        .program_mode(program_mode), .fail_flag(fail_flag), .locked_out(locked_out),
        .fail_count(fail_count), .code_changed(code_changed), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one key for exactly one rising edge, then sample 1 time unit later.
    task automatic press(input logic [3:0] k);
        @(negedge clk);
        keypad_value = k;
        keypress = 1'b1;
        @(posedge clk);
        #1;
        keypress = 1'b0;
        keypad_value = 4'h0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        press(a); press(b); press(c); press(d); press(4'hA);
    endtask

    initial begin
        // Reset state
        step(2);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        chk("rst_entry", 32'(entry_digits), 32'h0);
        chk("rst_count", 32'(digit_count), 0);
        chk("rst_unlocked", 32'(unlocked), 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_failcnt", 32'(fail_count), 0);
        chk("rst_flags", 32'({program_mode, fail_flag, locked_out, code_changed}), 0);

        // 1: correct code unlocks, relocks after exactly 20 cycles
        press(4'h1); press(4'h2); press(4'h3); press(4'h4);
        chk("t1_entry", 32'(entry_digits), 32'h1234);
        chk("t1_count", 32'(digit_count), 4);
        press(4'hA);
        chk("t1_unlocked", 32'(unlocked), 1);
        chk("t1_rgb", 32'(rgb), 32'b010);
        chk("t1_cleared", 32'(digit_count), 0);
        step(19);
        chk("t1_still_unlocked", 32'(unlocked), 1);
        step(1);
        chk("t1_relock", 32'(unlocked), 0);
        chk("t1_relock_rgb", 32'(rgb), 0);

        // 2: wrong code -> FAIL for 10 cycles, then correct code clears count
        enter4(4'h1, 4'h2, 4'h3, 4'h5);
        chk("t2_fail", 32'(fail_flag), 1);
        chk("t2_failcnt", 32'(fail_count), 1);
        chk("t2_rgb", 32'(rgb), 32'b001);
        step(9);
        chk("t2_fail_hold", 32'(fail_flag), 1);
        step(1);
        chk("t2_fail_end", 32'(fail_flag), 0);
        chk("t2_failcnt_kept", 32'(fail_count), 1);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("t2_unlock", 32'(unlocked), 1);
        chk("t2_failcnt_zero", 32'(fail_count), 0);
        press(4'hD);
        chk("t2_lockkey", 32'(unlocked), 0);

        // 3: three wrong entries -> LOCKOUT for 50 cycles
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        step(10);
        enter4(4'h0, 4'h0, 4'h0, 4'h0);
        chk("t3_failcnt2", 32'(fail_count), 2);
        step(10);
        press(4'hA);
        chk("t3_lockout", 32'(locked_out), 1);
        chk("t3_not_fail", 32'(fail_flag), 0);
        chk("t3_failcnt3", 32'(fail_count), 3);
        press(4'h5); press(4'h6);
        chk("t3_keys_ignored", 32'(digit_count), 0);
        step(47);
        chk("t3_lockout_hold", 32'(locked_out), 1);
        step(1);
        chk("t3_lockout_end", 32'(locked_out), 0);
        chk("t3_failcnt_clr", 32'(fail_count), 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("t3_unlock", 32'(unlocked), 1);
        press(4'hD);

        // 4: fifth digit ignored, CLEAR, short entry fails
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        chk("t4_entry", 32'(entry_digits), 32'h1234);
        chk("t4_count", 32'(digit_count), 4);
        press(4'hB);
        chk("t4_clear_entry", 32'(entry_digits), 0);
        chk("t4_clear_count", 32'(digit_count), 0);
        press(4'h7); press(4'h8);
        chk("t4_partial", 32'(entry_digits), 32'h0078);
        press(4'hA);
        chk("t4_fail", 32'(fail_flag), 1);
        chk("t4_failcnt", 32'(fail_count), 1);
        step(10);

        // 5: reprogram to 9876
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        press(4'hC);
        chk("t5_prog", 32'(program_mode), 1);
        chk("t5_prog_unl", 32'(unlocked), 1);
        chk("t5_prog_rgb", 32'(rgb), 32'b100);
        enter4(4'h9, 4'h8, 4'h7, 4'h6);
        chk("t5_changed", 32'(code_changed), 1);
        chk("t5_entry_state", 32'({unlocked, program_mode}), 0);
        step(1);
        chk("t5_changed_pulse", 32'(code_changed), 0);
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("t5_old_fails", 32'(fail_flag), 1);
        step(10);
        enter4(4'h9, 4'h8, 4'h7, 4'h6);
        chk("t5_new_unlock", 32'(unlocked), 1);

        // Short ENTER in PROGRAM returns to UNLOCKED
        press(4'hC);
        press(4'h1);
        press(4'hA);
        chk("t5_short_enter", 32'({unlocked, program_mode}), 32'b10);

        // 6: reset in PROGRAM restores default code
        press(4'hC);
        press(4'h1); press(4'h2);
        chk("t6_pre_count", 32'(digit_count), 2);
        @(negedge clk);
        rst = 1'b1;
        step(1);
        chk("t6_rst_entry", 32'(entry_digits), 0);
        chk("t6_rst_count", 32'(digit_count), 0);
        chk("t6_rst_flags", 32'({unlocked, program_mode, fail_flag, locked_out, code_changed}), 0);
        chk("t6_rst_rgb", 32'(rgb), 0);
        @(negedge clk);
        rst = 1'b0;
        enter4(4'h1, 4'h2, 4'h3, 4'h4);
        chk("t6_default_code", 32'(unlocked), 1);

        // Keypress on the expiry edge is dropped
        step(19);
        press(4'hC);
        chk("t6_expiry_wins", 32'({unlocked, program_mode}), 0);
        chk("t6_expiry_count", 32'(digit_count), 0);
        press(4'h3);
        chk("t6_entry_live", 32'(entry_digits), 32'h0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
